// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done request bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    // start is sampled only in IDLE; a/b are captured on that accepting edge and may change
    // afterwards. busy is high during RUN, done pulses one cycle when diff/flags update, and
    // results hold until the next completed operation. Starts during RUN/DONE are dropped.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
    state_t           dbg_state;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero, dbg_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero, dbg_state
    );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - bin, bout is the borrow out.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single registered borrow.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-2:0]   r_res_sh;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_overflow;
    logic               r_zero;

    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    full_subtractor_bit u_bit (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // The result register only keeps WIDTH-1 bits; the newest bit completes the word.
    assign w_res_next = {w_d, r_res_sh};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_cnt      <= '0;
            r_br       <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sh   <= bus.a;
                        r_b_sh   <= bus.b;
                        r_a_msb  <= bus.a[WIDTH-1];
                        r_b_msb  <= bus.b[WIDTH-1];
                        r_res_sh <= '0;
                        r_br     <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next[WIDTH-1:1];
                    r_br     <= w_bout;
                    if (w_last) begin
                        r_diff     <= w_res_next;
                        r_borrow   <= w_bout;
                        r_overflow <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                        r_zero     <= (w_res_next == '0);
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake/boundary cases at WIDTH 8 and randomized runs at 2/8/16.
module tb_serial_subtractor;
    import sub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst8_n;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packed as {zero, overflow, borrow, diff[31:0]}.
    function automatic logic [34:0] ref_sub(input int w, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        logic [31:0] d;
        logic        br;
        logic        ov;
        logic        z;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        d    = (a - b) & mask;
        br   = (a & mask) < (b & mask);
        ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
        z    = (d == 32'd0);
        return {z, ov, br, d};
    endfunction

    // ---------------- directed WIDTH=8 instance ----------------
    serial_subtractor_if #(.WIDTH(8)) d8_if ();
    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (d8_if.slave)
    );

    logic [34:0] exp8_q[$];
    logic [34:0] e8;

    always @(negedge clk) begin
        if (d8_if.done === 1'b1) begin
            if (exp8_q.size() == 0) begin
                check_val("d8_unexpected_done", 1, 0);
            end else begin
                e8 = exp8_q.pop_front();
                check_val("d8_scoreboard", {d8_if.zero, d8_if.overflow, d8_if.borrow, 24'd0, d8_if.diff}, e8);
            end
        end
    end

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input logic eo, input logic ez, input bit poke);
        int busy_n;
        int cyc;
        bit stable;
        @(negedge clk);
        d8_if.start = 1'b1;
        d8_if.a     = a;
        d8_if.b     = b;
        exp8_q.push_back(ref_sub(8, {24'd0, a}, {24'd0, b}));
        @(negedge clk);
        d8_if.start = 1'b0;
        d8_if.a     = 8'($urandom);
        d8_if.b     = 8'($urandom);
        busy_n = 0;
        cyc    = 0;
        while (d8_if.done !== 1'b1 && cyc < 40) begin
            if (d8_if.busy === 1'b1) busy_n++;
            if (poke && cyc == 3) begin
                d8_if.start = 1'b1;
                d8_if.a     = 8'h11;
            end else begin
                d8_if.start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        check_val({tag, "_busy_cycles"}, busy_n, 8);
        check_val({tag, "_done_latency"}, cyc, 8);
        check_val({tag, "_done"}, d8_if.done, 1);
        check_val({tag, "_busy_at_done"}, d8_if.busy, 0);
        check_val({tag, "_diff"}, d8_if.diff, ed);
        check_val({tag, "_borrow"}, d8_if.borrow, eb);
        check_val({tag, "_overflow"}, d8_if.overflow, eo);
        check_val({tag, "_zero"}, d8_if.zero, ez);
        if (poke) begin
            d8_if.start = 1'b1;
            d8_if.a     = 8'h11;
        end
        @(negedge clk);
        d8_if.start = 1'b0;
        check_val({tag, "_done_one_cycle"}, d8_if.done, 0);
        if (poke) begin
            stable = 1'b1;
            repeat (12) begin
                @(negedge clk);
                if (d8_if.done !== 1'b0 || d8_if.busy !== 1'b0 || d8_if.diff !== ed || d8_if.zero !== ez)
                    stable = 1'b0;
            end
            check_val({tag, "_ignored_start_hold"}, stable, 1);
        end
    endtask

    // ---------------- randomized instances at several widths ----------------
    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 16);

        serial_subtractor_if #(.WIDTH(W)) bif ();
        serial_subtractor #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bif.slave)
        );

        logic [34:0] exp_q[$];
        logic [34:0] e;
        int sent = 0;
        int seen = 0;
        bit fin  = 1'b0;

        always @(negedge clk) begin
            if (bif.done === 1'b1) begin
                seen++;
                if (exp_q.size() == 0) begin
                    check_val($sformatf("w%0d_unexpected_done", W), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val($sformatf("w%0d_result", W), {bif.zero, bif.overflow, bif.borrow, 32'(bif.diff)}, e);
                end
            end
        end

        initial begin
            logic [31:0] ra;
            logic [31:0] rb;
            int gap;
            bif.start = 1'b0;
            bif.a     = '0;
            bif.b     = '0;
            wait (rst_n === 1'b1);
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
                case (i)
                    0: rb = ra;
                    1: begin ra = 32'd0; rb = 32'd1; end
                    2: begin ra = 32'd1 << (W - 1); rb = 32'd1; end
                    3: begin ra = (32'd1 << (W - 1)) - 32'd1; rb = 32'hFFFF_FFFF; end
                    default: ;
                endcase
                @(negedge clk);
                bif.start = 1'b1;
                bif.a     = ra[W-1:0];
                bif.b     = rb[W-1:0];
                exp_q.push_back(ref_sub(W, ra, rb));
                sent++;
                @(negedge clk);
                bif.start = 1'b0;
                bif.a     = ~ra[W-1:0];
                repeat (W) @(negedge clk);
                // The first 100 operations run at the minimum accept spacing.
                if (i >= 100) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) @(negedge clk);
                end
            end
            repeat (W + 4) @(negedge clk);
            check_val($sformatf("w%0d_done_count", W), seen, sent);
            check_val($sformatf("w%0d_queue_empty", W), exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        bit busy_seen;
        int cyc;
        rst_n       = 1'b0;
        rst8_n      = 1'b0;
        d8_if.start = 1'b0;
        d8_if.a     = '0;
        d8_if.b     = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rst8_n = 1'b1;

        busy_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (d8_if.busy !== 1'b0) busy_seen = 1'b1;
        end
        check_val("rst_busy_never", busy_seen, 0);
        check_val("rst_done", d8_if.done, 0);
        check_val("rst_diff", d8_if.diff, 0);
        check_val("rst_borrow", d8_if.borrow, 0);
        check_val("rst_overflow", d8_if.overflow, 0);
        check_val("rst_zero", d8_if.zero, 0);
        check_val("rst_state", d8_if.dbg_state, ST_IDLE);

        op8("basic",   8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0, 1'b0);
        op8("wrap",    8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        op8("ovf_neg", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        op8("ovf_pos", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        op8("zero",    8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Abort an operation four cycles into RUN.
        @(negedge clk);
        d8_if.start = 1'b1;
        d8_if.a     = 8'h5A;
        d8_if.b     = 8'h23;
        @(negedge clk);
        d8_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_busy_before", d8_if.busy, 1);
        #2 rst8_n = 1'b0;
        #1;
        check_val("abort_busy", d8_if.busy, 0);
        check_val("abort_done", d8_if.done, 0);
        check_val("abort_diff", d8_if.diff, 0);
        check_val("abort_borrow", d8_if.borrow, 0);
        check_val("abort_overflow", d8_if.overflow, 0);
        check_val("abort_zero", d8_if.zero, 0);
        check_val("abort_state", d8_if.dbg_state, ST_IDLE);
        repeat (3) @(negedge clk);
        check_val("abort_no_done", d8_if.done, 0);
        rst8_n = 1'b1;
        op8("post_abort", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("d8_queue_empty", exp8_q.size(), 0);

        cyc = 0;
        while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("random_runs_complete", {g_w[0].fin, g_w[1].fin, g_w[2].fin}, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
